// File: rtl/vga_write_queue.sv
// vga_write_queue: buffers PicoBlaze text-memory writes in a FIFO and
// replays them to the VGA controller only during vertical retrace.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   Port_ID, IN_DATA  processor I/O bus (port id, write data)
//   Write_Strobe      processor write strobe
//   Read_Strobe       processor read strobe
//   OUT_DATA          status read {5'd0, overflow, full, empty}, 0 if unselected
//   VSync             active-low sync from the VGA controller
//   VGA_Port_ID       registered port id to the VGA controller
//   VGA_DATA          registered data to the VGA controller
//   VGA_Write_Strobe  registered write strobe to the VGA controller
module vga_write_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [7:0]  ADDR_PORT   = 8'd40,
  parameter logic [7:0]  DATA_PORT   = 8'd41,
  parameter logic [7:0]  STATUS_PORT = 8'd3,
  parameter logic [7:0]  CLR_PORT    = 8'd42
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Port_ID,
  input  logic [7:0] IN_DATA,
  input  logic       Write_Strobe,
  input  logic       Read_Strobe,
  output logic [7:0] OUT_DATA,
  input  logic       VSync,
  output logic [7:0] VGA_Port_ID,
  output logic [7:0] VGA_DATA,
  output logic       VGA_Write_Strobe
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} state_t;

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    addr_stage;
  logic          overflow;
  logic          vsync_q;
  state_t        state;
  state_t        state_nx;

  logic        full;
  logic        empty;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        clr;
  logic [11:0] head;
  logic        stb_nx;
  logic [7:0]  port_nx;
  logic [7:0]  data_nx;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = Write_Strobe && (Port_ID == DATA_PORT);
  assign push     = push_req && !full;
  assign pop      = (state == DATA);
  assign clr      = Write_Strobe && (Port_ID == CLR_PORT);
  assign head     = mem[rd_ptr];

  assign OUT_DATA = (Read_Strobe && (Port_ID == STATUS_PORT))
                  ? {5'd0, overflow, full, empty} : 8'd0;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {addr_stage, IN_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      addr_stage <= 4'hF;
      overflow   <= 1'b0;
      vsync_q    <= 1'b1;
    end else begin
      vsync_q <= VSync;
      if (Write_Strobe && (Port_ID == ADDR_PORT))
        addr_stage <= IN_DATA[3:0];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
      // a dropped push outranks a same-cycle clear
      if (push_req && full) overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  // outputs are computed for the state being entered and registered
  // with it, so they line up with the state cycle
  always_comb begin
    state_nx = state;
    stb_nx   = 1'b0;
    port_nx  = 8'd0;
    data_nx  = 8'd0;
    unique case (state)
      IDLE: begin
        if (!empty && !vsync_q) begin
          state_nx = ADDR;
          stb_nx   = 1'b1;
          port_nx  = ADDR_PORT;
          data_nx  = {4'd0, head[11:8]};
        end
      end
      ADDR: begin
        state_nx = DATA;
        stb_nx   = 1'b1;
        port_nx  = DATA_PORT;
        data_nx  = head[7:0];
      end
      DATA:    state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= IDLE;
      VGA_Port_ID      <= 8'd0;
      VGA_DATA         <= 8'd0;
      VGA_Write_Strobe <= 1'b0;
    end else begin
      state            <= state_nx;
      VGA_Port_ID      <= port_nx;
      VGA_DATA         <= data_nx;
      VGA_Write_Strobe <= stb_nx;
    end
  end

endmodule

// File: tb/tb_vga_write_queue.sv
// tb_vga_write_queue: directed bench for vga_write_queue with a queue model
// checking every downstream cycle plus hand-computed timing checks.
module tb_vga_write_queue;

  localparam int DEPTH = 16;
  localparam logic [7:0] AP = 8'd40;
  localparam logic [7:0] DP = 8'd41;
  localparam logic [7:0] SP = 8'd3;
  localparam logic [7:0] CP = 8'd42;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] Port_ID;
  logic [7:0] IN_DATA;
  logic       Write_Strobe;
  logic       Read_Strobe;
  logic [7:0] OUT_DATA;
  logic       VSync;
  logic [7:0] VGA_Port_ID;
  logic [7:0] VGA_DATA;
  logic       VGA_Write_Strobe;

  int total = 0;
  int bad = 0;

  logic [11:0] mq[$];
  logic        m_ovf;
  logic [3:0]  m_addr;
  bit          phase;
  int          run;

  vga_write_queue #(
    .DEPTH(DEPTH), .ADDR_PORT(AP), .DATA_PORT(DP),
    .STATUS_PORT(SP), .CLR_PORT(CP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Port_ID(Port_ID), .IN_DATA(IN_DATA),
    .Write_Strobe(Write_Strobe), .Read_Strobe(Read_Strobe),
    .OUT_DATA(OUT_DATA), .VSync(VSync), .VGA_Port_ID(VGA_Port_ID),
    .VGA_DATA(VGA_DATA), .VGA_Write_Strobe(VGA_Write_Strobe)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {5'd0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    Port_ID = p;
    IN_DATA = d;
    Write_Strobe = 1'b1;
    if (p == AP) m_addr = d[3:0];
    if (p == CP) m_ovf = 1'b0;
    if (p == DP) begin
      if (mq.size() < DEPTH) mq.push_back({m_addr, d});
      else m_ovf = 1'b1;
    end
    tick();
    Port_ID = 8'd0;
    IN_DATA = 8'd0;
    Write_Strobe = 1'b0;
  endtask

  task automatic status(input string nm, input logic [7:0] exp);
    Port_ID = SP;
    Read_Strobe = 1'b1;
    #1;
    chk(nm, OUT_DATA, exp);
    chk({nm, "_model"}, OUT_DATA, m_status());
    Read_Strobe = 1'b0;
    Port_ID = 8'd0;
  endtask

  task automatic wait_port(input logic [7:0] p, input int lim,
                           input string nm);
    int i = 0;
    while (!(VGA_Write_Strobe && VGA_Port_ID == p) && i < lim) begin
      tick();
      i++;
    end
    total++;
    if (i >= lim) begin
      bad++;
      $display("FAIL %s actual=no strobe required=port %0d", nm, p);
    end
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int i = 0;
    while (mq.size() != 0 && i < lim) begin
      tick();
      i++;
    end
    chk(nm, mq.size(), 0);
  endtask

  task automatic chk_out(input string nm, input logic s,
                         input logic [7:0] p, input logic [7:0] d);
    chk({nm, "_stb"}, VGA_Write_Strobe, s);
    chk({nm, "_port"}, VGA_Port_ID, p);
    chk({nm, "_data"}, VGA_DATA, d);
  endtask

  // every non-reset cycle: strobes must match the model stream in
  // push order as addr/data pairs, quiet cycles must drive zeros
  always @(negedge CLK) begin
    if (RESET) begin
      run = 0;
    end else if (VGA_Write_Strobe) begin
      run++;
      chk("strobe_run_le2", run <= 2, 1);
      if (mq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual=port %0d data %0h required=none",
                 VGA_Port_ID, VGA_DATA);
      end else if (!phase) begin
        chk("model_addr_port", VGA_Port_ID, AP);
        chk("model_addr_data", VGA_DATA, {4'h0, mq[0][11:8]});
        phase = 1'b1;
      end else begin
        chk("model_data_port", VGA_Port_ID, DP);
        chk("model_data_data", VGA_DATA, mq[0][7:0]);
        void'(mq.pop_front());
        phase = 1'b0;
      end
    end else begin
      run = 0;
      chk("quiet_port", VGA_Port_ID, 0);
      chk("quiet_data", VGA_DATA, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    VSync = 1'b1;
    Port_ID = 8'd0;
    IN_DATA = 8'd0;
    Write_Strobe = 1'b0;
    Read_Strobe = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_addr = 4'hF;
    phase = 1'b0;
    run = 0;

    // reset values
    repeat (3) tick();
    chk_out("rst", 1'b0, 8'd0, 8'd0);
    status("rst_status", 8'h01);
    RESET = 1'b0;
    VSync = 1'b0;
    tick();
    tick();

    // single write, VSync low
    wr(AP, 8'h05);
    wr(DP, 8'hA7);
    chk("sw_t1_stb", VGA_Write_Strobe, 0);
    status("sw_t1_status", 8'h00);
    tick();
    chk_out("sw_addr", 1'b1, AP, 8'h05);
    tick();
    chk_out("sw_data", 1'b1, DP, 8'hA7);
    tick();
    chk_out("sw_gap", 1'b0, 8'd0, 8'd0);
    tick();
    status("sw_after", 8'h01);

    // hold until retrace
    VSync = 1'b1;
    tick();
    wr(AP, 8'h01); wr(DP, 8'h11);
    wr(AP, 8'h02); wr(DP, 8'h22);
    wr(AP, 8'h03); wr(DP, 8'h33);
    repeat (4) tick();
    chk("hold_stb", VGA_Write_Strobe, 0);
    status("hold_status", 8'h00);
    VSync = 1'b0;
    tick();
    chk("hold_s1_stb", VGA_Write_Strobe, 0);
    tick();
    chk_out("hold_e1a", 1'b1, AP, 8'h01);
    tick();
    chk_out("hold_e1d", 1'b1, DP, 8'h11);
    tick();
    tick();
    chk("hold_idle_stb", VGA_Write_Strobe, 0);
    tick();
    chk_out("hold_e2a", 1'b1, AP, 8'h02);
    VSync = 1'b1;
    tick();
    chk_out("hold_e2d", 1'b1, DP, 8'h22);
    repeat (6) begin
      tick();
      chk("hold_wait_stb", VGA_Write_Strobe, 0);
    end
    status("hold_e3_status", 8'h00);
    VSync = 1'b0;
    tick();
    tick();
    chk_out("hold_e3a", 1'b1, AP, 8'h03);
    tick();
    chk_out("hold_e3d", 1'b1, DP, 8'h33);
    tick();
    tick();
    status("hold_end", 8'h01);

    // overflow
    VSync = 1'b1;
    tick();
    wr(AP, 8'h07);
    for (int i = 0; i < 17; i++) wr(DP, 8'(8'h80 + i));
    status("ovf_status", 8'h06);
    wr(CP, 8'h00);
    status("clr_status", 8'h02);
    VSync = 1'b0;
    wait_drain(16 * 4 + 10, "ovf_drain");
    repeat (8) tick();
    status("ovf_end", 8'h01);

    // push lands in every DATA cycle across pointer wrap
    VSync = 1'b1;
    tick();
    wr(AP, 8'h0A);
    wr(DP, 8'hC0);
    wr(DP, 8'hC1);
    VSync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_port(AP, 12, "pp_addr");
      tick();
      wr(DP, 8'(i * 5 + 1));
      wr(AP, 8'(i));
      status("pp_status", 8'h00);
      chk("pp_count", mq.size(), 2);
    end
    wait_drain(20, "pp_drain");
    repeat (4) tick();
    status("pp_end", 8'h01);

    // reset during DATA cycle
    VSync = 1'b1;
    tick();
    wr(AP, 8'h05);
    wr(DP, 8'h55);
    wr(DP, 8'h66);
    VSync = 1'b0;
    wait_port(DP, 12, "rm_data");
    RESET = 1'b1;
    tick();
    mq.delete();
    phase = 1'b0;
    m_ovf = 1'b0;
    m_addr = 4'hF;
    chk_out("rm_after", 1'b0, 8'd0, 8'd0);
    status("rm_status", 8'h01);
    RESET = 1'b0;
    repeat (20) begin
      tick();
      chk("rm_quiet_stb", VGA_Write_Strobe, 0);
    end

    // address stage defaults to F after reset
    wr(DP, 8'h3C);
    wait_port(AP, 12, "def_addr");
    chk("def_addr_data", VGA_DATA, 8'h0F);
    tick();
    chk_out("def_data", 1'b1, DP, 8'h3C);
    wait_drain(10, "def_drain");
    repeat (4) tick();
    status("def_end", 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
